lcd_spectrum_show: RTL and testbench

LCD-side consumer of the spectrum FIFO read controller. Runs on lcd_clk. Once per frame it requests the 64 magnitude bins one at a time through the data_req/wr_over handshake and scales each into a bar height in a 64-entry register buffer. It then renders a bar graph from that buffer into the LCD pixel stream.

---
 rtl/lcd_spectrum_show.sv | 200 ++++++++++++++++++++
 tb/tb_lcd_spectrum_show.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_spectrum_show.sv
// Fetches the spectrum bins once per frame into a bar-height buffer and renders a bar graph.
// Optional peak-hold markers are built when PEAK_HOLD_EN is defined.
module lcd_spectrum_show #(
  parameter int          NUM_BINS   = 64,
  parameter int          DATA_LAT   = 3,
  parameter int          MAG_SHIFT  = 6,
  parameter int          BAR_MAX    = 200,
  parameter int          X_START    = 16,
  parameter int          BAR_W_LOG2 = 2,
  parameter int          Y_BASE     = 260,
  parameter logic [15:0] BAR_COLOR  = 16'h07E0,
  parameter logic [15:0] BG_COLOR   = 16'h0000,
  parameter logic [15:0] PEAK_COLOR = 16'hF800
) (
  input  logic        lcd_clk,
  input  logic        sys_rst,
  input  logic        frame_start,
  output logic        data_req,
  output logic        wr_over,
  input  logic [6:0]  rd_cnt,
  input  logic [15:0] fifo_rd_data,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  output logic [15:0] pixel_data,
  output logic        busy
);

  localparam int BIN_W = $clog2(NUM_BINS);
  localparam int WCW   = $clog2(DATA_LAT) + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [BIN_W-1:0] bin_cnt_r, bin_nxt_s;
  logic [WCW-1:0]   wait_cnt_r, wait_nxt_s;
  logic             capture_s, start_s;
  logic             data_req_r, wr_over_r, busy_r;
  logic [15:0]      pixel_data_r, pixel_nxt_s;
  logic [15:0]      mag_shift_s;
  logic [8:0]       h_s;
  logic [8:0]       height_r [NUM_BINS];
  logic [10:0]      x_off_s, bin_full_s;
  logic [BIN_W-1:0] pix_bin_s;
  logic [8:0]       pix_h_s;
  logic             in_win_s, lit_s, peak_hit_s;
  logic             unused_s;

  assign unused_s   = rd_cnt[6];
  assign data_req   = data_req_r;
  assign wr_over    = wr_over_r;
  assign busy       = busy_r;
  assign pixel_data = pixel_data_r;

  // Fetch sequencer next-state logic
  always_comb begin
    state_nxt_s = state_r;
    bin_nxt_s   = bin_cnt_r;
    wait_nxt_s  = wait_cnt_r;
    capture_s   = 1'b0;
    start_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (frame_start) begin
          state_nxt_s = S_REQ;
          bin_nxt_s   = {BIN_W{1'b0}};
          start_s     = 1'b1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_REQ: begin
        wait_nxt_s  = WCW'(DATA_LAT - 1);
        state_nxt_s = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_r == {WCW{1'b0}}) begin
          capture_s   = 1'b1;
          state_nxt_s = S_DONE;
        end else begin
          wait_nxt_s  = wait_cnt_r - WCW'(1);
        end
      end
      S_DONE: state_nxt_s = S_GAP;
      S_GAP: begin
        if (bin_cnt_r == BIN_W'(NUM_BINS - 1)) begin
          state_nxt_s = S_IDLE;
        end else begin
          bin_nxt_s   = bin_cnt_r + BIN_W'(1);
          state_nxt_s = S_REQ;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Sequencer state and handshake outputs, registered so each strobe spans exactly its state
  always_ff @(posedge lcd_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_r    <= S_IDLE;
      bin_cnt_r  <= {BIN_W{1'b0}};
      wait_cnt_r <= {WCW{1'b0}};
      data_req_r <= 1'b0;
      wr_over_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      bin_cnt_r  <= bin_nxt_s;
      wait_cnt_r <= wait_nxt_s;
      data_req_r <= (state_nxt_s == S_REQ);
      wr_over_r  <= (state_nxt_s == S_DONE);
      busy_r     <= (state_nxt_s != S_IDLE);
    end
  end

  // Magnitude to bar height: shift, then clamp to the tallest drawable bar
  always_comb begin
    mag_shift_s = fifo_rd_data >> MAG_SHIFT;
    if (mag_shift_s > 16'(BAR_MAX)) begin
      h_s = 9'(BAR_MAX);
    end else begin
      h_s = mag_shift_s[8:0];
    end
  end

  // Height buffer, indexed by the controller's bin counter
  always_ff @(posedge lcd_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      for (int i = 0; i < NUM_BINS; i++) height_r[i] <= 9'd0;
    end else if (capture_s) begin
      height_r[rd_cnt[BIN_W-1:0]] <= h_s;
    end
  end

  // Pixel-to-bin mapping; the top test compares ypos + h against the baseline to avoid underflow
  always_comb begin
    x_off_s    = pixel_xpos - 11'(X_START);
    bin_full_s = x_off_s >> BAR_W_LOG2;
    pix_bin_s  = bin_full_s[BIN_W-1:0];
    in_win_s   = (pixel_xpos >= 11'(X_START)) && (bin_full_s < 11'(NUM_BINS));
    pix_h_s    = height_r[pix_bin_s];
    lit_s      = in_win_s && (pix_h_s != 9'd0) && (pixel_ypos <= 11'(Y_BASE)) &&
                 (({1'b0, pixel_ypos} + {3'b000, pix_h_s}) > 12'(Y_BASE));
  end

`ifdef PEAK_HOLD_EN
  logic [8:0] peak_r [NUM_BINS];
  logic [8:0] pix_p_s;

  // Peak buffer: capture raises a peak, each accepted frame decays all peaks by one
  always_ff @(posedge lcd_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      for (int i = 0; i < NUM_BINS; i++) peak_r[i] <= 9'd0;
    end else begin
      for (int i = 0; i < NUM_BINS; i++) begin
        if (capture_s && (rd_cnt[BIN_W-1:0] == BIN_W'(i)) && (h_s >= peak_r[i])) begin
          peak_r[i] <= h_s;
        end else if (start_s && (peak_r[i] != 9'd0)) begin
          peak_r[i] <= peak_r[i] - 9'd1;
        end
      end
    end
  end

  // Peak marker row sits at Y_BASE - peak
  always_comb begin
    pix_p_s    = peak_r[pix_bin_s];
    peak_hit_s = in_win_s && (pix_p_s != 9'd0) &&
                 (({1'b0, pixel_ypos} + {3'b000, pix_p_s}) == 12'(Y_BASE));
  end
`else
  assign peak_hit_s = 1'b0;
`endif

  // Colour select; the peak marker overrides the bar
  always_comb begin
    if (peak_hit_s) begin
      pixel_nxt_s = PEAK_COLOR;
    end else if (lit_s) begin
      pixel_nxt_s = BAR_COLOR;
    end else begin
      pixel_nxt_s = BG_COLOR;
    end
  end

  // Registered pixel output
  always_ff @(posedge lcd_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      pixel_data_r <= BG_COLOR;
    end else begin
      pixel_data_r <= pixel_nxt_s;
    end
  end

endmodule

// File: tb/tb_lcd_spectrum_show.sv
// Directed self-checking bench for lcd_spectrum_show with a behavioural FIFO read controller.
module tb_lcd_spectrum_show;

  localparam logic [15:0] BAR  = 16'h07E0;
  localparam logic [15:0] BG   = 16'h0000;
  localparam logic [15:0] PEAK = 16'hF800;

  logic        lcd_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        frame_start = 1'b0;
  logic        data_req, wr_over, busy;
  logic [6:0]  rd_cnt;
  logic [15:0] fifo_rd_data;
  logic [10:0] pixel_xpos = 11'd0;
  logic [10:0] pixel_ypos = 11'd0;
  logic [15:0] pixel_data;
  logic [15:0] mem [64];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 lcd_clk = ~lcd_clk;

  lcd_spectrum_show dut (
    .lcd_clk(lcd_clk), .sys_rst(sys_rst), .frame_start(frame_start),
    .data_req(data_req), .wr_over(wr_over), .rd_cnt(rd_cnt),
    .fifo_rd_data(fifo_rd_data), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .pixel_data(pixel_data), .busy(busy)
  );

  // Read controller model: advances the bin index on each consumed bin
  always @(posedge lcd_clk or negedge sys_rst) begin
    if (!sys_rst) rd_cnt <= 7'd0;
    else if (wr_over) rd_cnt <= rd_cnt + 7'd1;
  end
  assign fifo_rd_data = mem[rd_cnt[5:0]];

  task automatic get_pix(input int x, input int y, output logic [15:0] p);
    @(negedge lcd_clk);
    pixel_xpos = 11'(x);
    pixel_ypos = 11'(y);
    @(negedge lcd_clk);
    p = pixel_data;
  endtask

  task automatic fill_mem(input logic [15:0] v);
    for (int i = 0; i < 64; i++) mem[i] = v;
  endtask

  task automatic run_frame(input string name);
    int n;
    @(negedge lcd_clk); frame_start = 1'b1;
    @(negedge lcd_clk); frame_start = 1'b0;
    n = 0;
    while (busy && n < 500) begin
      @(negedge lcd_clk);
      n++;
    end
    n_checks++;
    if (n !== 384) begin
      n_fail++;
      $display("FAIL %s frame_len: got %0d cycles, expected 384", name, n);
    end
  endtask

  task automatic test_reset;
    sys_rst = 1'b0;
    fill_mem(16'h0000);
    repeat (3) @(negedge lcd_clk);
    sys_rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      pixel_xpos = 11'(i * 3);
      pixel_ypos = 11'(i * 3);
      @(negedge lcd_clk);
      n_checks++;
      if (data_req !== 1'b0 || wr_over !== 1'b0 || busy !== 1'b0 || pixel_data !== BG) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: req=%b over=%b busy=%b pix=%h, expected 0 0 0 0000",
                 i, data_req, wr_over, busy, pixel_data);
      end
    end
  endtask

  task automatic test_handshake;
    int wr_pulses;
    logic [15:0] p;
    fill_mem(16'h1900);
    @(negedge lcd_clk); frame_start = 1'b1;
    @(negedge lcd_clk); frame_start = 1'b0;
    wr_pulses = 0;
    for (int c = 0; c < 390; c++) begin
      logic exp_req, exp_over, exp_busy;
      exp_req  = (c < 384) && (c % 6 == 0);
      exp_over = (c < 384) && (c % 6 == 4);
      exp_busy = (c < 384);
      if (wr_over === 1'b1) wr_pulses++;
      n_checks++;
      if (data_req !== exp_req || wr_over !== exp_over || busy !== exp_busy) begin
        n_fail++;
        $display("FAIL handshake cyc %0d: req=%b over=%b busy=%b, expected %b %b %b",
                 c, data_req, wr_over, busy, exp_req, exp_over, exp_busy);
      end
      @(negedge lcd_clk);
    end
    n_checks++;
    if (wr_pulses !== 64) begin
      n_fail++;
      $display("FAIL wr_over_count: got %0d, expected 64", wr_pulses);
    end
    for (int k = 0; k < 64; k++) begin
      get_pix(16 + 4 * k, 161, p);
      n_checks++;
      if (p !== BAR) begin
        n_fail++;
        $display("FAIL height_top bin %0d: got %h, expected %h", k, p, BAR);
      end
      get_pix(16 + 4 * k + 3, 160, p);
      n_checks++;
      if (p !== BG) begin
        n_fail++;
        $display("FAIL height_above bin %0d: got %h, expected %h", k, p, BG);
      end
    end
  endtask

  task automatic test_clamp;
    logic [15:0] p;
    fill_mem(16'h1900);
    mem[5] = 16'hFFFF;
    mem[6] = 16'h003F;
    run_frame("clamp");
    get_pix(36, 61, p);
    n_checks++;
    if (p !== BAR) begin n_fail++; $display("FAIL clamp_top: got %h, expected %h", p, BAR); end
    get_pix(36, 60, p);
    n_checks++;
    if (p !== BG) begin n_fail++; $display("FAIL clamp_above: got %h, expected %h", p, BG); end
    get_pix(39, 260, p);
    n_checks++;
    if (p !== BAR) begin n_fail++; $display("FAIL clamp_base: got %h, expected %h", p, BAR); end
    for (int y = 0; y < 262; y += 3) begin
      get_pix((y % 2 == 0) ? 40 : 43, y, p);
      n_checks++;
      if (p !== BG) begin
        n_fail++;
        $display("FAIL bin6_empty y=%0d: got %h, expected %h", y, p, BG);
      end
    end
  endtask

  task automatic test_window;
    int          xs [8] = '{15, 16, 16, 16, 271, 272, 271, 2047};
    int          ys [8] = '{200, 200, 260, 261, 200, 200, 160, 200};
    logic [15:0] es [8] = '{BG, BAR, BAR, BG, BAR, BG, BG, BG};
    logic [15:0] p;
    for (int i = 0; i < 8; i++) begin
      get_pix(xs[i], ys[i], p);
      n_checks++;
      if (p !== es[i]) begin
        n_fail++;
        $display("FAIL window x=%0d y=%0d: got %h, expected %h", xs[i], ys[i], p, es[i]);
      end
    end
  endtask

  task automatic test_ignore_restart;
    int reqs;
    fill_mem(16'h1900);
    @(negedge lcd_clk); frame_start = 1'b1;
    @(negedge lcd_clk); frame_start = 1'b0;
    reqs = 0;
    for (int c = 0; c < 400; c++) begin
      if (c == 50) frame_start = 1'b1;
      if (c == 51) frame_start = 1'b0;
      if (data_req === 1'b1) reqs++;
      if (c == 383 || c == 384) begin
        n_checks++;
        if (busy !== (c == 383)) begin
          n_fail++;
          $display("FAIL restart_busy cyc %0d: got %b, expected %b", c, busy, (c == 383));
        end
      end
      @(negedge lcd_clk);
    end
    n_checks++;
    if (reqs !== 64) begin
      n_fail++;
      $display("FAIL restart_reqs: got %0d, expected 64", reqs);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] p;
    get_pix(16, 200, p);
    @(negedge lcd_clk); frame_start = 1'b1;
    @(negedge lcd_clk); frame_start = 1'b0;
    for (int c = 0; c < 200; c++) @(negedge lcd_clk);
    n_checks++;
    if (busy !== 1'b1 || pixel_data !== BAR) begin
      n_fail++;
      $display("FAIL pre_reset: busy=%b pix=%h, expected 1 %h", busy, pixel_data, BAR);
    end
    sys_rst = 1'b0;
    #1;
    n_checks++;
    if (data_req !== 1'b0 || wr_over !== 1'b0 || busy !== 1'b0 || pixel_data !== BG) begin
      n_fail++;
      $display("FAIL mid_reset: req=%b over=%b busy=%b pix=%h, expected 0 0 0 0000",
               data_req, wr_over, busy, pixel_data);
    end
    @(negedge lcd_clk); sys_rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge lcd_clk);
      n_checks++;
      if (busy !== 1'b0 || data_req !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_idle cyc %0d: busy=%b req=%b, expected 0 0", c, busy, data_req);
      end
    end
    get_pix(16, 200, p);
    n_checks++;
    if (p !== BG) begin n_fail++; $display("FAIL heights_cleared: got %h, expected %h", p, BG); end
    fill_mem(16'h0C80);
    run_frame("after_reset");
    get_pix(56, 211, p);
    n_checks++;
    if (p !== BAR) begin n_fail++; $display("FAIL refetch_top: got %h, expected %h", p, BAR); end
    get_pix(56, 210, p);
    n_checks++;
    if (p !== BG) begin n_fail++; $display("FAIL refetch_above: got %h, expected %h", p, BG); end
    n_checks++;
    if (rd_cnt !== 7'd64) begin
      n_fail++;
      $display("FAIL refetch_count: got %0d, expected 64", rd_cnt);
    end
  endtask

`ifdef PEAK_HOLD_EN
  task automatic test_peak;
    logic [15:0] p;
    @(negedge lcd_clk); sys_rst = 1'b0;
    @(negedge lcd_clk); sys_rst = 1'b1;
    fill_mem(16'h0000);
    mem[3] = 16'h1900;
    run_frame("peak1");
    get_pix(28, 160, p);
    n_checks++;
    if (p !== PEAK) begin n_fail++; $display("FAIL peak_first: got %h, expected %h", p, PEAK); end
    get_pix(28, 161, p);
    n_checks++;
    if (p !== BAR) begin n_fail++; $display("FAIL peak_bar: got %h, expected %h", p, BAR); end
    mem[3] = 16'h0000;
    run_frame("peak2");
    get_pix(28, 161, p);
    n_checks++;
    if (p !== PEAK) begin n_fail++; $display("FAIL peak_decay1: got %h, expected %h", p, PEAK); end
    get_pix(28, 200, p);
    n_checks++;
    if (p !== BG) begin n_fail++; $display("FAIL peak_bar_empty: got %h, expected %h", p, BG); end
    for (int f = 0; f < 10; f++) run_frame("peak_decay");
    get_pix(28, 171, p);
    n_checks++;
    if (p !== PEAK) begin n_fail++; $display("FAIL peak_decay11: got %h, expected %h", p, PEAK); end
    get_pix(28, 170, p);
    n_checks++;
    if (p !== BG) begin n_fail++; $display("FAIL peak_old_row: got %h, expected %h", p, BG); end
  endtask
`endif

  initial begin
    test_reset;
    test_handshake;
    test_clamp;
    test_window;
    test_ignore_restart;
    test_reset_mid;
`ifdef PEAK_HOLD_EN
    test_peak;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
